pe_fetch_unit: RTL
==================

Name: pe_fetch_unit

Overview:
- Initiator side of the 4-lane instruction-memory read interface.
- One independent fetch lane per PE. Each lane keeps a program counter, drives `read_enable`/`PC` to the shared instruction memory and captures the returned `instruction` word.
- Delivers instructions in order to each PE's decode stage through a valid/ready handshake. Each lane has a 2-entry buffer (output register + skid) and supports branch redirect.

Parameters:
- NUM_PE, 4, number of PE lanes.
- XLEN, 32, width of PC and instruction per lane.
- RESET_PC, 0, PC value loaded into every lane at reset.
- PC_STEP, 1, PC increment per issued fetch (memory is word-addressed).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- enable  in  NUM_PE  per-lane run; 0 = issue no new fetches.
- redirect_valid  in  NUM_PE  per-lane branch/jump redirect strobe.
- redirect_pc  in  NUM_PE*XLEN  redirect target; lane i uses bits [i*XLEN +: XLEN].
- read_enable  out  NUM_PE  fetch request to instruction memory, one bit per lane.
- PC  out  NUM_PE*XLEN  fetch address per lane, same packing as redirect_pc.
- instruction  in  NUM_PE*XLEN  memory read data; lane i valid exactly 1 cycle after read_enable[i]=1.
- instr_valid  out  NUM_PE  per-lane output valid.
- instr_out  out  NUM_PE*XLEN  per-lane output instruction.
- instr_pc  out  NUM_PE*XLEN  PC the output instruction was fetched from.
- instr_ready  in  NUM_PE  per-lane consumer ready.

Behaviour:
- Lanes are fully independent; every rule below is per lane i.
- State per lane:
  - pc_q;
  - infl_q: a request was issued last cycle;
  - drop_q: discard the next response;
  - out slot (valid, instr, pc);
  - skid slot (valid, instr, pc);
  - inflight address register.
- Reset (rst=1 at an edge): pc_q=RESET_PC; infl_q, drop_q, out valid and skid valid all cleared.
  - While rst=1: read_enable=0, PC=RESET_PC, instr_valid=0, instr_out=0, instr_pc=0.
  - Reset mid-operation discards all buffered and in-flight data; the response arriving the cycle after reset is ignored.
- pop = instr_valid & instr_ready.
- occ = out_valid + skid_valid + infl_q − pop.
- Issue: read_enable = enable & ~redirect_valid & ~rst & (occ < 2). Combinational from state and inputs.
- PC = pc_q (combinational).
- On issue: pc_q <= pc_q + PC_STEP, wrapping modulo 2^XLEN; infl_q <= 1; the issuing PC is latched for instr_pc. Otherwise infl_q <= 0.
- Capture: in the cycle with infl_q=1 and drop_q=0, the instruction lane is accepted and the capture rules below apply in the same edge.
- Output/skid update (order always preserved):
  - pop with skid valid: out <= skid; new response (if any) goes to skid.
  - pop with skid empty: out <= new response if any, else out empties.
  - No pop: a new response fills out if out is empty, else fills skid.
  - The occ<2 rule guarantees skid never overflows.
  - Out and skid hold stable while instr_ready=0.
- Redirect (redirect_valid=1) has priority over issue, capture and pop:
  - pc_q <= redirect_pc;
  - out and skid cleared (instr_valid=0 next cycle);
  - drop_q <= infl_q;
  - read_enable=0 in the redirect cycle.
  - First fetch of the target is issued the next cycle if enable=1.
  - pop in the redirect cycle is ignored by the lane.
- Drop: a response with drop_q=1 is discarded and drop_q clears.
- enable=0: issue stops. In-flight responses are still captured and the buffers still drain. Redirects are still accepted (pc loaded only).
- Throughput: 1 instruction/cycle per lane with instr_ready held high. First instr_valid appears 2 cycles after the first read_enable cycle (1-cycle memory latency + output register).

Test Plan:
- Reset then enable=4'b1111, instr_ready all 1, memory word n = 0x1000+n.
  - Lane 0 PC sequence 0,1,2,…, read_enable high every cycle.
  - instr_out lane 0 = 0x1000,0x1001,… on consecutive cycles from cycle 2, with instr_pc matching.
- Lane 1: hold instr_ready=0 for 5 cycles.
  - read_enable[1] asserts for exactly 2 cycles then drops; instr_out stays 0x1000.
  - On ready=1 outputs 0x1000,0x1001,0x1002 back-to-back; no loss or duplicate.
  - Other lanes unaffected.
- Lane 2 redirect to 0x40 while a fetch is in flight.
  - Stale in-flight word is never presented; instr_valid[2]=0 the cycle after redirect.
  - Next read_enable[2] uses PC=0x40; the first output after the redirect has instr_pc=0x40.
- enable=4'b1010 mid-stream.
  - Lanes 0 and 2 stop issuing but deliver already fetched words.
  - Lanes 1 and 3 continue at full rate.
- Lane 3 with pc_q=0xFFFFFFFF issuing: next PC=0x00000000 (wrap).
- Assert rst for 1 cycle with lanes full and in flight.
  - Next cycle all instr_valid=0, PC=RESET_PC.
  - The response arriving after reset is not presented.

Source files
------------

// File: rtl/pe_fetch_unit.sv
// pe_fetch_unit
//   Initiator side of a multi-lane instruction-memory read interface. Each PE
//   lane owns a program counter, issues word reads to the shared instruction
//   memory, and hands returned words to its decode stage in order through a
//   valid/ready handshake. Each lane buffers up to two words (output register
//   plus skid) and accepts branch/jump redirects.
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst             synchronous active-high reset
//   enable          per-lane run; 0 stops new fetches
//   redirect_valid  per-lane redirect strobe
//   redirect_pc     per-lane redirect target, lane i at [i*XLEN +: XLEN]
//   read_enable     per-lane fetch request to instruction memory
//   PC              per-lane fetch address (same packing as redirect_pc)
//   instruction     per-lane read data, valid one cycle after read_enable
//   instr_valid     per-lane output valid
//   instr_out       per-lane output instruction
//   instr_pc        per-lane address the output instruction came from
//   instr_ready     per-lane consumer ready
module pe_fetch_unit #(
  parameter int              NUM_PE   = 4,
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] PC_STEP  = XLEN'(1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_PE-1:0]      enable,
  input  logic [NUM_PE-1:0]      redirect_valid,
  input  logic [NUM_PE*XLEN-1:0] redirect_pc,
  output logic [NUM_PE-1:0]      read_enable,
  output logic [NUM_PE*XLEN-1:0] PC,
  input  logic [NUM_PE*XLEN-1:0] instruction,
  output logic [NUM_PE-1:0]      instr_valid,
  output logic [NUM_PE*XLEN-1:0] instr_out,
  output logic [NUM_PE*XLEN-1:0] instr_pc,
  input  logic [NUM_PE-1:0]      instr_ready
);

  for (genvar i = 0; i < NUM_PE; i++) begin : g_lane

    // Control state (reset) and data state (qualified by the valid bits).
    logic            infl_q, infl_d;
    logic            drop_q, drop_d;
    logic            out_valid_q, out_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] infl_pc_q, infl_pc_d;
    logic [XLEN-1:0] out_instr_q, out_instr_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [XLEN-1:0] skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;

    logic            pop;
    logic            cap;
    logic            issue;
    logic [1:0]      occ;
    logic [XLEN-1:0] rsp;

    assign rsp = instruction[i*XLEN +: XLEN];
    assign pop = out_valid_q & instr_ready[i] & ~rst;
    // pop implies out_valid_q, so the subtraction never underflows.
    assign occ = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(infl_q) - 2'(pop);
    assign cap = infl_q & ~drop_q;
    // Occupancy counts the in-flight word, so a stalled lane stops issuing
    // before the skid could overflow.
    assign issue = enable[i] & ~redirect_valid[i] & ~rst & (occ < 2'd2);

    assign read_enable[i]               = issue;
    assign PC[i*XLEN +: XLEN]           = rst ? RESET_PC : pc_q;
    assign instr_valid[i]               = out_valid_q & ~rst;
    assign instr_out[i*XLEN +: XLEN]    = rst ? '0 : out_instr_q;
    assign instr_pc[i*XLEN +: XLEN]     = rst ? '0 : out_pc_q;

    always_comb begin
      // NOTE: every variable gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      pc_d         = pc_q;
      infl_pc_d    = infl_pc_q;
      infl_d       = issue;
      // drop_q only covers the cycle right after a redirect; it is cleared
      // unconditionally afterwards so it can never swallow a target word.
      drop_d       = 1'b0;
      out_valid_d  = out_valid_q;
      out_instr_d  = out_instr_q;
      out_pc_d     = out_pc_q;
      skid_valid_d = skid_valid_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;

      if (issue) begin
        pc_d      = pc_q + PC_STEP;
        infl_pc_d = pc_q;
      end

      if (redirect_valid[i]) begin
        // Redirect wins over capture and pop: the word returning now and
        // everything buffered belong to the abandoned path.
        pc_d         = redirect_pc[i*XLEN +: XLEN];
        out_valid_d  = 1'b0;
        skid_valid_d = 1'b0;
        drop_d       = infl_q;
      end else if (pop) begin
        if (skid_valid_q) begin
          out_valid_d  = 1'b1;
          out_instr_d  = skid_instr_q;
          out_pc_d     = skid_pc_q;
          skid_valid_d = cap;
          skid_instr_d = rsp;
          skid_pc_d    = infl_pc_q;
        end else begin
          out_valid_d = cap;
          out_instr_d = rsp;
          out_pc_d    = infl_pc_q;
        end
      end else if (cap) begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_instr_d = rsp;
          out_pc_d    = infl_pc_q;
        end else begin
          skid_valid_d = 1'b1;
          skid_instr_d = rsp;
          skid_pc_d    = infl_pc_q;
        end
      end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
      if (rst) begin
        pc_q         <= RESET_PC;
        infl_q       <= 1'b0;
        drop_q       <= 1'b0;
        out_valid_q  <= 1'b0;
        skid_valid_q <= 1'b0;
      end else begin
        pc_q         <= pc_d;
        infl_q       <= infl_d;
        drop_q       <= drop_d;
        out_valid_q  <= out_valid_d;
        skid_valid_q <= skid_valid_d;
      end
    end

    // NOTE: payload registers carry no reset; the valid bits above make their
    // contents irrelevant until written, and the outputs are forced to zero
    // while rst is high.
    always_ff @(posedge clk) begin
      infl_pc_q    <= infl_pc_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end

  end : g_lane

endmodule
